branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/bp_pkg.sv | 24 ++
 rtl/branch_predictor_sat_counter2.sv | 22 ++
 rtl/branch_predictor.sv | 132 +++++++++++++
 tb/tb_branch_predictor.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: 2-bit counter encoding, BTB entry
// layout and the default table size.
package bp_pkg;

    localparam int BP_ENTRIES_DEF = 16;
    // Widest tag occurs at the smallest table (4 entries): 32 - 2 - 2 bits.
    localparam int BP_TAG_W       = 28;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr2_e;

    // Tag is stored zero-extended so one struct serves every table size.
    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic [29:0]         target;
        ctr2_e               ctr;
    } btb_entry_t;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Saturating 2-bit direction counter: next state from current state and outcome.
module sat_counter2
    import bp_pkg::*;
(
    input  ctr2_e i_state,
    input  logic  i_taken,
    output ctr2_e o_next
);

    // Step toward taken or not-taken, holding at either end.
    always_comb begin
        o_next = i_state;
        case (i_state)
            SNT:     o_next = i_taken ? WNT : SNT;
            WNT:     o_next = i_taken ? WT  : SNT;
            WT:      o_next = i_taken ? ST  : WNT;
            ST:      o_next = i_taken ? ST  : WT;
            default: o_next = i_state;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters, prediction pipeline to Execute and
// mispredict/redirect generation. Define BP_PERF_CNT_EN to add the
// BranchCount/MispredictCount performance counter ports.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = BP_ENTRIES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCF,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        FlushE,
    output logic [31:0] PredictedPCF,
    output logic        PredictTakenF,
    output logic        fetch_predicted_addr_E,
    input  logic [31:0] PCE,
    input  logic        BranchE,
    input  logic        BranchTakenE,
    input  logic [31:0] BranchTargetE,
    input  logic        Correct_addr_prediction,
    output logic        MispredictE,
    output logic [31:0] RedirectPCE
`ifdef BP_PERF_CNT_EN
    ,
    output logic [31:0] BranchCount,
    output logic [31:0] MispredictCount
`endif
);

    localparam int IDX = $clog2(ENTRIES);

    btb_entry_t          r_btb [ENTRIES];
    logic                r_pred_d;
    logic                r_pred_e;

    logic [IDX-1:0]      w_idx_f;
    logic [IDX-1:0]      w_idx_e;
    logic [BP_TAG_W-1:0] w_tag_f;
    logic [BP_TAG_W-1:0] w_tag_e;
    btb_entry_t          w_rd_f;
    btb_entry_t          w_rd_e;
    logic                w_hit_f;
    logic                w_hit_e;
    ctr2_e               w_ctr_next;
    logic                w_unused;

    assign w_idx_f = PCF[IDX+1:2];
    assign w_idx_e = PCE[IDX+1:2];
    assign w_tag_f = BP_TAG_W'(PCF[31:IDX+2]);
    assign w_tag_e = BP_TAG_W'(PCE[31:IDX+2]);
    assign w_rd_f  = r_btb[w_idx_f];
    assign w_rd_e  = r_btb[w_idx_e];
    assign w_hit_f = w_rd_f.valid && (w_rd_f.tag == w_tag_f);
    assign w_hit_e = w_rd_e.valid && (w_rd_e.tag == w_tag_e);

    // Fetch-side lookup reads the registered table, so a same-cycle update
    // to the same index is only seen on the following cycle.
    assign PredictTakenF = w_hit_f & w_rd_f.ctr[1];
    assign PredictedPCF  = {w_rd_f.target, 2'b00};

    assign fetch_predicted_addr_E = r_pred_e;
    assign MispredictE = BranchE & ((r_pred_e ^ BranchTakenE) |
                                    (r_pred_e & BranchTakenE & ~Correct_addr_prediction));
    assign RedirectPCE = BranchTakenE ? BranchTargetE : (PCE + 32'd4);

    sat_counter2 u_sat (
        .i_state (w_rd_e.ctr),
        .i_taken (BranchTakenE),
        .o_next  (w_ctr_next)
    );

    // BTB training from resolved branches in Execute; reset wins over update.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_btb[i].valid  <= 1'b0;
                r_btb[i].tag    <= '0;
                r_btb[i].target <= '0;
                r_btb[i].ctr    <= WNT;
            end
        end else if (BranchE) begin
            if (w_hit_e) begin
                r_btb[w_idx_e].ctr <= w_ctr_next;
                if (BranchTakenE) begin
                    r_btb[w_idx_e].target <= BranchTargetE[31:2];
                end
            end else if (BranchTakenE) begin
                r_btb[w_idx_e] <= '{valid: 1'b1, tag: w_tag_e,
                                    target: BranchTargetE[31:2], ctr: WT};
            end
        end
    end

    // Carry the fetch prediction to Execute; flush takes priority over stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pred_d <= 1'b0;
            r_pred_e <= 1'b0;
        end else begin
            if (FlushD)       r_pred_d <= 1'b0;
            else if (!StallF) r_pred_d <= PredictTakenF;
            if (FlushE)       r_pred_e <= 1'b0;
            else if (!StallD) r_pred_e <= r_pred_d;
        end
    end

`ifdef BP_PERF_CNT_EN
    logic [31:0] r_branch_cnt;
    logic [31:0] r_mispredict_cnt;

    // Free-running wrap-around event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else begin
            if (BranchE)     r_branch_cnt     <= r_branch_cnt + 32'd1;
            if (MispredictE) r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
        end
    end

    assign BranchCount     = r_branch_cnt;
    assign MispredictCount = r_mispredict_cnt;
`endif

    // Low PC bits are always zero for word-aligned code and are ignored.
    assign w_unused = ^{PCF[1:0], PCE[1:0], BranchTargetE[1:0], w_rd_f.ctr[0], w_rd_e.target};

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (default 16-entry table).
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PCF;
    logic        StallF, StallD, FlushD, FlushE;
    logic [31:0] PredictedPCF;
    logic        PredictTakenF;
    logic        fetch_predicted_addr_E;
    logic [31:0] PCE;
    logic        BranchE, BranchTakenE;
    logic [31:0] BranchTargetE;
    logic        Correct_addr_prediction;
    logic        MispredictE;
    logic [31:0] RedirectPCE;
`ifdef BP_PERF_CNT_EN
    logic [31:0] BranchCount, MispredictCount;
`endif

    int checks   = 0;
    int failures = 0;

    branch_predictor dut (
        .clk                     (clk),
        .reset                   (reset),
        .PCF                     (PCF),
        .StallF                  (StallF),
        .StallD                  (StallD),
        .FlushD                  (FlushD),
        .FlushE                  (FlushE),
        .PredictedPCF            (PredictedPCF),
        .PredictTakenF           (PredictTakenF),
        .fetch_predicted_addr_E  (fetch_predicted_addr_E),
        .PCE                     (PCE),
        .BranchE                 (BranchE),
        .BranchTakenE            (BranchTakenE),
        .BranchTargetE           (BranchTargetE),
        .Correct_addr_prediction (Correct_addr_prediction),
        .MispredictE             (MispredictE),
        .RedirectPCE             (RedirectPCE)
`ifdef BP_PERF_CNT_EN
        ,
        .BranchCount             (BranchCount),
        .MispredictCount         (MispredictCount)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; PCF = 32'h100; StallF = 0; StallD = 0; FlushD = 0; FlushE = 0;
        PCE = 32'h0; BranchE = 0; BranchTakenE = 0; BranchTargetE = 32'h0;
        Correct_addr_prediction = 1'b1;
        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst_pred_f", 32'(PredictTakenF), 32'd0);
        check("rst_pred_e", 32'(fetch_predicted_addr_E), 32'd0);
        check("rst_mispred", 32'(MispredictE), 32'd0);

        // Every index misses after reset
        for (int i = 0; i < 16; i++) begin
            PCF = 32'h100 + 32'(i * 4);
            #1;
            check("rst_sweep", 32'(PredictTakenF), 32'd0);
        end

        // Taken branch at 0x100 -> 0x140, allocated weakly taken
        PCF = 32'h100; PCE = 32'h100; BranchE = 1; BranchTakenE = 1; BranchTargetE = 32'h140;
        #1;
        check("same_cycle_old", 32'(PredictTakenF), 32'd0);
        check("alloc_mispred", 32'(MispredictE), 32'd1);
        check("alloc_redirect", RedirectPCE, 32'h140);
        tick();
        BranchE = 0;
        #1;
        check("alloc_pred", 32'(PredictTakenF), 32'd1);
        check("alloc_target", PredictedPCF, 32'h140);

        // Not-taken three times: WT->WNT->SNT->SNT
        BranchE = 1; BranchTakenE = 0;
        tick();
        check("nt1_pred", 32'(PredictTakenF), 32'd0);
        tick();
        check("nt2_pred", 32'(PredictTakenF), 32'd0);
        tick();
        check("nt3_pred", 32'(PredictTakenF), 32'd0);
        check("nt_target_kept", PredictedPCF, 32'h140);
        // From SNT one taken reaches only WNT; a second reaches WT
        BranchTakenE = 1;
        tick();
        check("snt_plus1", 32'(PredictTakenF), 32'd0);
        tick();
        check("snt_plus2", 32'(PredictTakenF), 32'd1);
        BranchE = 0;

        // Prediction travels F -> D -> E
        tick();
        check("pipe_e_1", 32'(fetch_predicted_addr_E), 32'd0);
        tick();
        check("pipe_e_2", 32'(fetch_predicted_addr_E), 32'd1);

        // Predicted taken, resolved taken, target correct / wrong
        BranchE = 1; BranchTakenE = 1; BranchTargetE = 32'h200; Correct_addr_prediction = 1;
        #1;
        check("tgt_ok_mispred", 32'(MispredictE), 32'd0);
        Correct_addr_prediction = 0;
        #1;
        check("tgt_bad_mispred", 32'(MispredictE), 32'd1);
        check("tgt_bad_redirect", RedirectPCE, 32'h200);
        tick();
        Correct_addr_prediction = 1;
        BranchE = 0;
        #1;
        check("tgt_rewritten", PredictedPCF, 32'h200);
        check("tgt_pred", 32'(PredictTakenF), 32'd1);
        check("no_branch_mispred", 32'(MispredictE), 32'd0);

        // Predicted taken, resolved not taken at top of memory -> wraps to 0
        BranchE = 1; BranchTakenE = 0; PCE = 32'hFFFF_FFFC;
        #1;
        check("wrap_mispred", 32'(MispredictE), 32'd1);
        check("wrap_redirect", RedirectPCE, 32'h0);
        tick();
        BranchE = 0;
        PCF = 32'hFFFF_FFFC;
        #1;
        check("miss_nt_no_alloc", 32'(PredictTakenF), 32'd0);

        // Stall holds PredE; flush beats stall
        PCF = 32'h100;
        tick(); tick();
        check("pre_stall_e", 32'(fetch_predicted_addr_E), 32'd1);
        PCF = 32'h0; StallD = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold_e", 32'(fetch_predicted_addr_E), 32'd1);
        end
        FlushE = 1;
        tick();
        check("flush_over_stall", 32'(fetch_predicted_addr_E), 32'd0);
        FlushE = 0; StallD = 0;

        // FlushD beats StallF
        PCF = 32'h100; StallF = 1; FlushD = 1;
        tick();
        FlushD = 0; StallF = 0; PCF = 32'h0;
        tick();
        check("flushd_over_stallf", 32'(fetch_predicted_addr_E), 32'd0);

        // Reset wins over a same-cycle update and clears the table
        reset = 1; BranchE = 1; BranchTakenE = 1; PCE = 32'h300; BranchTargetE = 32'h340;
        tick();
        reset = 0; BranchE = 0; PCF = 32'h300;
        #1;
        check("rst_blocks_update", 32'(PredictTakenF), 32'd0);
        PCF = 32'h100;
        #1;
        check("rst_clears_entry", 32'(PredictTakenF), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
